// File: rtl/imm_ext_pkg.sv
// Shared definitions for the decode-stage immediate generator:
// format selects, field positions and the shift constants.
package imm_ext_pkg;

    typedef enum logic [2:0] {
        ZE12 = 3'd0,
        SE9  = 3'd1,
        SE19 = 3'd2,
        SE26 = 3'd3,
        ZE16 = 3'd4
    } imm_mode_t;

    localparam int ZE12_LSB = 10;
    localparam int ZE12_MSB = 21;
    localparam int SE9_LSB  = 12;
    localparam int SE9_MSB  = 20;
    localparam int SE19_LSB = 5;
    localparam int SE19_MSB = 23;
    localparam int SE26_LSB = 0;
    localparam int SE26_MSB = 25;
    localparam int ZE16_LSB = 5;
    localparam int ZE16_MSB = 20;

    // Half-word select for MOVZ-style immediates
    localparam int HW_SEL_LSB = 21;
    localparam int HW_SEL_MSB = 22;

    localparam int BR_SHIFT      = 2;
    localparam int HW_SHIFT_UNIT = 16;

endpackage

// File: rtl/imm_field_format.sv
// Combinational immediate extraction: picks the field for the selected
// format, extends it to DATA_W and applies the branch / half-word shift.
module imm_field_format
    import imm_ext_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int INSTR_W = 32
) (
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [2:0]         mode_i,
    output logic [DATA_W-1:0]  imm_o,
    output logic               err_o
);

    logic [1:0] hw_sel;
    logic [7:0] hw_shamt;
    logic       hw_overflow;

    assign hw_sel      = instr_i[HW_SEL_MSB:HW_SEL_LSB];
    assign hw_shamt    = 8'(hw_sel) * 8'(HW_SHIFT_UNIT);
    // A half-word placed at or beyond DATA_W would lose every bit of the field
    assign hw_overflow = (hw_shamt >= 8'(DATA_W));

    always_comb begin
        imm_o = '0;
        err_o = 1'b0;
        case (mode_i)
            ZE12: imm_o = DATA_W'(instr_i[ZE12_MSB:ZE12_LSB]);
            SE9:  imm_o = DATA_W'($signed(instr_i[SE9_MSB:SE9_LSB]));
            SE19: imm_o = DATA_W'($signed(instr_i[SE19_MSB:SE19_LSB])) << BR_SHIFT;
            SE26: imm_o = DATA_W'($signed(instr_i[SE26_MSB:SE26_LSB])) << BR_SHIFT;
            ZE16: begin
                if (hw_overflow) begin
                    err_o = 1'b1;
                end else begin
                    imm_o = DATA_W'(instr_i[ZE16_MSB:ZE16_LSB]) << hw_shamt;
                end
            end
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_extend_unit.sv
// Immediate generator with a small valid/ready output buffer so that
// register-read stalls never drop a formatted immediate.
module imm_extend_unit
    import imm_ext_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic [2:0]         mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  imm_out,
    output logic               err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic              err_q  [DEPTH];

    logic [DATA_W-1:0] fmt_imm;
    logic              fmt_err;
    logic              push, pop;

    imm_field_format #(
        .DATA_W  (DATA_W),
        .INSTR_W (INSTR_W)
    ) u_format (
        .instr_i (instr),
        .mode_i  (mode),
        .imm_o   (fmt_imm),
        .err_o   (fmt_err)
    );

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: it is only visible while count is non-zero
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push && (wr_ptr_q == PTR_W'(gi))) begin
                data_q[gi] <= fmt_imm;
                err_q[gi]  <= fmt_err;
            end
        end
    end

    assign imm_out = out_valid ? data_q[rd_ptr_q] : '0;
    assign err     = out_valid ? err_q[rd_ptr_q]  : 1'b0;

endmodule

// File: tb/tb_imm_extend_unit.sv
// Directed bench for imm_extend_unit: format table on 64- and 32-bit
// instances, plus backpressure, streaming, reset and idle sequences.
module tb_imm_extend_unit;
    import imm_ext_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [2:0]  mode;

    logic        in_ready, out_valid, err64;
    logic [63:0] imm64;
    logic        in_ready32, out_valid32, err32;
    logic [31:0] imm32;

    always #5 clk = ~clk;

    imm_extend_unit #(.DATA_W(64), .INSTR_W(32), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .imm_out(imm64), .err(err64)
    );

    imm_extend_unit #(.DATA_W(32), .INSTR_W(32), .DEPTH(2)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .mode(mode), .out_valid(out_valid32), .out_ready(out_ready),
        .imm_out(imm32), .err(err32)
    );

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  mode;
        logic [63:0] exp64;
        logic        experr64;
        logic [31:0] exp32;
        logic        experr32;
    } vec_t;

    vec_t vecs[15];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [11:0] val, exp_val;

    initial begin
        vecs[0]  = '{32'h002A_F000, 3'd0, 64'h0000_0000_0000_0ABC, 1'b0, 32'h0000_0ABC, 1'b0};
        vecs[1]  = '{32'h001F_0000, 3'd1, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 32'hFFFF_FFF0, 1'b0};
        vecs[2]  = '{32'h00FF_FFE0, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 1'b0};
        vecs[3]  = '{32'h0000_0010, 3'd3, 64'h0000_0000_0000_0040, 1'b0, 32'h0000_0040, 1'b0};
        vecs[4]  = '{32'h0057_DDE0, 3'd4, 64'h0000_BEEF_0000_0000, 1'b0, 32'h0000_0000, 1'b1};
        vecs[5]  = '{32'h0057_DDE0, 3'd7, 64'h0,                   1'b1, 32'h0000_0000, 1'b1};
        vecs[6]  = '{32'hFFFF_FFFF, 3'd0, 64'h0000_0000_0000_0FFF, 1'b0, 32'h0000_0FFF, 1'b0};
        vecs[7]  = '{32'hFFFF_FFFF, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0};
        vecs[8]  = '{32'h000F_F000, 3'd1, 64'h0000_0000_0000_00FF, 1'b0, 32'h0000_00FF, 1'b0};
        vecs[9]  = '{32'h03FF_FFFF, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 1'b0};
        vecs[10] = '{32'h007F_FFE0, 3'd4, 64'hFFFF_0000_0000_0000, 1'b0, 32'h0000_0000, 1'b1};
        vecs[11] = '{32'h0022_4680, 3'd4, 64'h0000_0000_1234_0000, 1'b0, 32'h1234_0000, 1'b0};
        vecs[12] = '{32'hFF9F_FFFF, 3'd4, 64'h0000_0000_0000_FFFF, 1'b0, 32'h0000_FFFF, 1'b0};
        vecs[13] = '{32'h0000_0000, 3'd5, 64'h0,                   1'b1, 32'h0000_0000, 1'b1};
        vecs[14] = '{32'h007F_FFE0, 3'd2, 64'h0000_0000_000F_FFFC, 1'b0, 32'h000F_FFFC, 1'b0};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; instr = '0; mode = '0;
        step(); step();
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset imm_out",   imm64,          64'd0);
        chk("reset err",       64'(err64),     64'd0);
        chk("reset in_ready",  64'(in_ready),  64'd1);
        reset = 1'b0;

        // Streamed table: each vector is visible one edge after acceptance
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1; instr = vecs[i].instr; mode = vecs[i].mode;
            step();
            $display("vec %0d mode %0d instr %h -> imm64 %h err %b imm32 %h err %b",
                     i, vecs[i].mode, vecs[i].instr, imm64, err64, imm32, err32);
            chk("tbl out_valid", 64'(out_valid), 64'd1);
            chk("tbl in_ready",  64'(in_ready),  64'd1);
            chk("tbl imm64",     imm64,          vecs[i].exp64);
            chk("tbl err64",     64'(err64),     64'(vecs[i].experr64));
            chk("tbl imm32",     64'(imm32),     64'(vecs[i].exp32));
            chk("tbl err32",     64'(err32),     64'(vecs[i].experr32));
        end
        in_valid = 1'b0;
        step();
        chk("drain out_valid", 64'(out_valid), 64'd0);
        chk("drain imm_out",   imm64,          64'd0);

        // Backpressure: A, B fill the buffer, C is held off
        out_ready = 1'b0; mode = 3'd0;
        in_valid = 1'b1; instr = 32'h111 << 10;
        step();
        $display("bp push A: out_valid %b imm %h in_ready %b", out_valid, imm64, in_ready);
        chk("bp A imm",      imm64,         64'h111);
        chk("bp A in_ready", 64'(in_ready), 64'd1);
        instr = 32'h222 << 10;
        step();
        $display("bp push B: out_valid %b imm %h in_ready %b", out_valid, imm64, in_ready);
        chk("bp B in_ready", 64'(in_ready), 64'd0);
        chk("bp hold imm 1", imm64,         64'h111);
        instr = 32'h333 << 10;
        step();
        $display("bp offer C: out_valid %b imm %h in_ready %b", out_valid, imm64, in_ready);
        chk("bp C in_ready", 64'(in_ready), 64'd0);
        chk("bp hold imm 2", imm64,         64'h111);
        out_ready = 1'b1;
        step();
        $display("bp pop A: imm %h in_ready %b", imm64, in_ready);
        chk("bp order B",   imm64,         64'h222);
        chk("bp ready back", 64'(in_ready), 64'd1);
        step();
        $display("bp pop B push C: imm %h", imm64);
        chk("bp order C",   imm64,          64'h333);
        chk("bp C valid",   64'(out_valid), 64'd1);
        in_valid = 1'b0;
        step();
        chk("bp empty",     64'(out_valid), 64'd0);

        // Simultaneous push/pop at count=1
        val = 12'(($urandom_range(0, 4095)));
        in_valid = 1'b1; instr = 32'(val) << 10; mode = 3'd0;
        step();
        for (int k = 0; k < 8; k++) begin
            exp_val = val;
            chk("pp prev imm", imm64, 64'(exp_val));
            val = 12'($urandom_range(0, 4095));
            instr = 32'(val) << 10;
            step();
            $display("pp cycle %0d: imm %h in_ready %b", k, imm64, in_ready);
            chk("pp out_valid", 64'(out_valid), 64'd1);
            chk("pp in_ready",  64'(in_ready),  64'd1);
        end
        chk("pp last imm", imm64, 64'(val));
        in_valid = 1'b0;
        step();
        chk("pp drained", 64'(out_valid), 64'd0);

        // Reset with a full buffer and a concurrent push
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h0AA << 10;
        step();
        instr = 32'h0BB << 10;
        step();
        chk("rst full", 64'(in_ready), 64'd0);
        reset = 1'b1; instr = 32'h0CC << 10;
        step();
        $display("mid reset: out_valid %b imm %h in_ready %b", out_valid, imm64, in_ready);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst imm_out",   imm64,          64'd0);
        chk("rst err",       64'(err64),     64'd0);
        chk("rst in_ready",  64'(in_ready),  64'd1);
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst no stale", 64'(out_valid), 64'd0);
        end

        // Idle with garbage inputs
        for (int k = 0; k < 10; k++) begin
            instr = $urandom; mode = 3'($urandom_range(0, 7));
            out_ready = 1'($urandom_range(0, 1));
            step();
            chk("idle out_valid", 64'(out_valid), 64'd0);
            chk("idle imm_out",   imm64,          64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/imm_extend_unit.md
Name: imm_extend_unit

Overview:
Parametrised immediate generator for the decode stage. It replaces the fixed 12-bit zero extender.
- Extracts the immediate field for the selected instruction format (I, D, CB, B, MOVZ) from a 32-bit instruction word.
- Zero- or sign-extends it to DATA_W, with optional branch scaling (<<2) and MOVZ half-word shift.
- Results go through a 2-entry valid/ready output buffer so a stall in the register-read/ALU side does not drop immediates.

Parameters:
- DATA_W, 64: output width. Legal values are 32 and 64.
- INSTR_W, 32: instruction width. Fixed at 32; the parameter exists for lint and package sharing.
- DEPTH, 2: output buffer entries. Legal values are 1 and 2.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- in_valid, input, 1: instr/mode are valid this cycle.
- in_ready, output, 1: unit can accept an input this cycle.
- instr, input, INSTR_W: raw instruction word.
- mode, input, 3: imm_mode_t format select.
- out_valid, output, 1: imm_out/err are valid.
- out_ready, input, 1: consumer accepts the head entry.
- imm_out, output, DATA_W: extended immediate.
- err, output, 1: head entry had an illegal mode or a shift that overflows DATA_W.

Behaviour:
- Reset:
  - Synchronous, active-high: clears count, read pointer and write pointer.
  - out_valid=0, imm_out=0, err=0, in_ready=1 on the cycle after reset is sampled.
  - Entries in flight when reset asserts are discarded. Reset wins over a simultaneous push or pop.
- Modes (imm_mode_t):
  - ZE12 (3'd0): instr[21:10], zero-extended.
  - SE9 (3'd1): instr[20:12], sign-extended.
  - SE19 (3'd2): instr[23:5], sign-extended, then <<2.
  - SE26 (3'd3): instr[25:0], sign-extended, then <<2.
  - ZE16 (3'd4): instr[20:5] zero-extended, then << (16*instr[22:21]).
  - 3'd5–3'd7: reserved. Result is 0 and err=1.
- Overflow: for ZE16 with DATA_W=32 and instr[22:21]>=2, result is 0 and err=1.
- Width arithmetic:
  - Sign extension replicates the field MSB up to bit DATA_W-1.
  - Shifts are performed at DATA_W. Bits shifted out are dropped; this is only possible for the ZE16 overflow case above.
- Push and pop:
  - Push when in_valid && in_ready; the formatted result is written at the write pointer.
  - Pop when out_valid && out_ready.
  - in_ready = (count != DEPTH). It is registered-state based and has no combinational path from out_ready.
- Latency:
  - 1 cycle: an input accepted at edge N is visible at out_valid/imm_out after edge N.
  - Throughput is 1 per cycle while out_ready=1.
- Outputs: out_valid = (count != 0). imm_out/err show the head entry and are forced to 0 when out_valid=0.
- Boundary conditions:
  - Empty, push only: count 0→1.
  - Full (count=DEPTH): in_ready=0 and in_valid is ignored. A pop that cycle gives count DEPTH-1, and in_ready rises the next cycle.
  - Simultaneous push and pop with 0<count<DEPTH: count unchanged, FIFO order preserved.
  - Pointers wrap modulo DEPTH.
  - in_valid=0 with garbage instr/mode: no state change.
- Held output: while out_valid=1 && out_ready=0, imm_out/err remain stable.

Decomposition:
- Package imm_ext_pkg:
  - typedef enum logic [2:0] imm_mode_t {ZE12, SE9, SE19, SE26, ZE16}.
  - Field LSB/MSB constants per mode.
  - BR_SHIFT=2 and HW_SHIFT_UNIT=16.
- Sub-module imm_field_format: purely combinational instr+mode → {err, DATA_W result}, parametrised on DATA_W.
- Top imm_extend_unit holds the buffer, pointers, count and handshake.

Test Plan:
- Three single pushes with out_ready=1:
  - ZE12, instr[21:10]=12'hABC → next cycle out_valid=1, imm_out=64'h0000_0000_0000_0ABC, err=0.
  - SE9, instr[20:12]=9'h1F0 → imm_out=64'hFFFF_FFFF_FFFF_FFF0.
  - SE19, instr[23:5]=19'h7FFFF → imm_out=64'hFFFF_FFFF_FFFF_FFFC.
- Back-to-back streaming:
  - SE26 with field 26'h0000010 → 64'h40.
  - ZE16 with imm16=16'hBEEF, hw=2 → 64'h0000_BEEF_0000_0000.
  - ZE16 with DATA_W=32 and hw=2 → imm_out=0, err=1.
  - Reserved mode 3'd7 → imm_out=0, err=1.
- Backpressure: out_ready=0, push A, B, C on consecutive cycles → in_ready drops after B and C is held. Raise out_ready → outputs A, B, C in order; imm_out is stable while stalled.
- Simultaneous push and pop at count=1 for 8 cycles → count stays 1, each output matches the input from one cycle earlier.
- Reset mid-stream: count=2, assert reset with in_valid=1 → next cycle out_valid=0, imm_out=0, in_ready=1, and no stale entry appears afterwards.
- Idle: in_valid=0 with random instr/mode → out_valid stays 0.
